// File: rtl/div_mon_pkg.sv
// Shared types for the divided-clock monitor: FSM states, the half-cycle
// sample pair and the counter saturation helper.
package div_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SYNC,
    ST_HIGH,
    ST_LOW
  } mon_state_e;

  // s0: half-cycle ending at the negedge, s1: half-cycle ending at the posedge.
  typedef struct packed {
    logic s0;
    logic s1;
  } hc_pair_t;

  function automatic int unsigned sat_max(input int unsigned width);
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/dual_edge_sampler.sv
// Captures the divided clock as data on both clk edges and hands the
// ordered half-cycle pair to the posedge domain.
module dual_edge_sampler
  import div_mon_pkg::*;
(
  input  logic     i_clk,
  input  logic     i_rst_n,
  input  logic     i_clk_div,
  output hc_pair_t o_pair,
  output logic     o_prev
);

  logic r_neg;
  logic r_pos;

  always_ff @(negedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_neg <= 1'b0;
    else          r_neg <= i_clk_div;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_pos <= 1'b0;
    else          r_pos <= i_clk_div;
  end

  // s1 is the live input: it is the half-cycle that the current posedge closes.
  assign o_pair.s0 = r_neg;
  assign o_pair.s1 = i_clk_div;
  assign o_prev    = r_pos;

endmodule

// File: rtl/div_clk_monitor.sv
// Measures high/low/period of a divided clock in clk half-cycles and tracks
// lock and a sticky error against the nominal ratio.
module div_clk_monitor
  import div_mon_pkg::*;
#(
  parameter int DIV_N    = 15,
  parameter int TOL      = 0,
  parameter int LOCK_CNT = 4,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk_div,
  input  logic             meas_en,
  output logic [CNT_W-1:0] high_len,
  output logic [CNT_W-1:0] low_len,
  output logic [CNT_W-1:0] period_len,
  output logic             meas_valid,
  output logic             lock,
  output logic             err,
  output logic [15:0]      period_cnt
);

  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(sat_max(CNT_W));
  localparam logic [CNT_W-1:0] HL_MIN  = CNT_W'(DIV_N - TOL);
  localparam logic [CNT_W-1:0] HL_MAX  = CNT_W'(DIV_N + TOL);
  localparam logic [CNT_W-1:0] P_MIN   = CNT_W'(2 * DIV_N - TOL);
  localparam logic [CNT_W-1:0] P_MAX   = CNT_W'(2 * DIV_N + TOL);
  localparam int               RUN_W   = $clog2(LOCK_CNT + 1);
  localparam logic [RUN_W-1:0] RUN_LOCK = RUN_W'(LOCK_CNT);

  typedef struct packed {
    mon_state_e       st;
    logic [CNT_W-1:0] h;
    logic [CNT_W-1:0] l;
    logic             pub;
    logic             sat;
    logic [CNT_W-1:0] pub_h;
    logic [CNT_W-1:0] pub_l;
  } step_t;

  // One half-cycle of FSM progress; applied twice per posedge (s0 then s1).
  function automatic step_t advance(input step_t a, input logic last, input logic x);
    step_t b;
    b = a;
    case (a.st)
      ST_SYNC: begin
        if (x && !last) begin
          b.st = ST_HIGH;
          b.h  = ONE;
        end
      end
      ST_HIGH: begin
        if (!x) begin
          b.st = ST_LOW;
          b.l  = ONE;
        end else begin
          b.h = a.h + ONE;
          if (b.h == CNT_MAX) begin
            b.sat = 1'b1;
            b.st  = ST_SYNC;
          end
        end
      end
      ST_LOW: begin
        if (x) begin
          b.pub   = 1'b1;
          b.pub_h = a.h;
          b.pub_l = a.l;
          b.st    = ST_HIGH;
          b.h     = ONE;
        end else begin
          b.l = a.l + ONE;
          if (b.l == CNT_MAX) begin
            b.sat = 1'b1;
            b.st  = ST_SYNC;
          end
        end
      end
      default: ;
    endcase
    return b;
  endfunction

  hc_pair_t         w_pair;
  logic             w_prev;
  step_t            w_init;
  step_t            w_mid;
  step_t            w_fin;
  logic [CNT_W:0]   w_sum;
  logic [CNT_W-1:0] w_period;
  logic             w_good;
  logic [RUN_W-1:0] w_run_inc;

  mon_state_e       r_state;
  logic [CNT_W-1:0] r_cnt_h;
  logic [CNT_W-1:0] r_cnt_l;
  logic [RUN_W-1:0] r_run;
  logic [CNT_W-1:0] r_high;
  logic [CNT_W-1:0] r_low;
  logic [CNT_W-1:0] r_period;
  logic             r_valid;
  logic             r_lock;
  logic             r_err;
  logic [15:0]      r_pcnt;

  dual_edge_sampler u_sampler (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_clk_div (clk_div),
    .o_pair    (w_pair),
    .o_prev    (w_prev)
  );

  // Leaving IDLE, the samples of the same cycle are already searched for an edge.
  always_comb begin
    w_init    = '0;
    w_init.st = (r_state == ST_IDLE) ? ST_SYNC : r_state;
    w_init.h  = r_cnt_h;
    w_init.l  = r_cnt_l;
  end

  assign w_mid = advance(w_init, w_prev, w_pair.s0);
  assign w_fin = advance(w_mid, w_pair.s0, w_pair.s1);

  assign w_sum     = {1'b0, w_fin.pub_h} + {1'b0, w_fin.pub_l};
  assign w_period  = w_sum[CNT_W] ? CNT_MAX : w_sum[CNT_W-1:0];
  assign w_good    = (w_fin.pub_h >= HL_MIN) && (w_fin.pub_h <= HL_MAX) &&
                     (w_fin.pub_l >= HL_MIN) && (w_fin.pub_l <= HL_MAX) &&
                     (w_period >= P_MIN) && (w_period <= P_MAX);
  assign w_run_inc = (r_run == RUN_LOCK) ? r_run : r_run + RUN_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_cnt_h  <= '0;
      r_cnt_l  <= '0;
      r_run    <= '0;
      r_high   <= '0;
      r_low    <= '0;
      r_period <= '0;
      r_valid  <= 1'b0;
      r_lock   <= 1'b0;
      r_err    <= 1'b0;
      r_pcnt   <= '0;
    end else if (!meas_en) begin
      r_state <= ST_IDLE;
      r_cnt_h <= '0;
      r_cnt_l <= '0;
      r_run   <= '0;
      r_valid <= 1'b0;
      r_lock  <= 1'b0;
      r_err   <= 1'b0;
      r_pcnt  <= '0;
    end else begin
      r_state <= w_fin.st;
      r_cnt_h <= w_fin.h;
      r_cnt_l <= w_fin.l;
      r_valid <= w_fin.pub;
      if (w_fin.pub) begin
        r_high   <= w_fin.pub_h;
        r_low    <= w_fin.pub_l;
        r_period <= w_period;
        r_pcnt   <= r_pcnt + 16'd1;
        if (w_good) begin
          r_run  <= w_run_inc;
          r_lock <= (w_run_inc == RUN_LOCK);
        end else begin
          r_run  <= '0;
          r_lock <= 1'b0;
          r_err  <= 1'b1;
        end
      end
      if (w_fin.sat) begin
        r_run  <= '0;
        r_lock <= 1'b0;
        r_err  <= 1'b1;
      end
    end
  end

  assign high_len   = r_high;
  assign low_len    = r_low;
  assign period_len = r_period;
  assign meas_valid = r_valid;
  assign lock       = r_lock;
  assign err        = r_err;
  assign period_cnt = r_pcnt;

endmodule

// File: tb/tb_div_clk_monitor.sv
// Directed bench for div_clk_monitor: nominal Div15, distorted periods,
// stuck input, reset/enable handling and an even divide-by-4 instance.
module tb_div_clk_monitor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        clk_div = 1'b0;
  logic        meas_en = 1'b0;
  logic        clk_div2 = 1'b0;
  logic        meas_en2 = 1'b0;
  logic [7:0]  high_len, low_len, period_len;
  logic [7:0]  high_len2, low_len2, period_len2;
  logic        meas_valid, lock, err;
  logic        meas_valid2, lock2, err2;
  logic [15:0] period_cnt, period_cnt2;

  int          n_checks = 0;
  int          n_fails = 0;
  int          cap_cnt = 0;
  int          cap2_cnt = 0;
  logic [7:0]  cap_h, cap_l, cap_p, cap2_h, cap2_l, cap2_p;
  logic        cap_lock, cap_err;
  logic [15:0] cap_pc;
  time         cap_t;
  time         rise_t;
  logic        rise_pos;

  div_clk_monitor u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clk_div    (clk_div),
    .meas_en    (meas_en),
    .high_len   (high_len),
    .low_len    (low_len),
    .period_len (period_len),
    .meas_valid (meas_valid),
    .lock       (lock),
    .err        (err),
    .period_cnt (period_cnt)
  );

  div_clk_monitor #(.DIV_N(4)) u_dut4 (
    .clk        (clk),
    .rst_n      (rst_n),
    .clk_div    (clk_div2),
    .meas_en    (meas_en2),
    .high_len   (high_len2),
    .low_len    (low_len2),
    .period_len (period_len2),
    .meas_valid (meas_valid2),
    .lock       (lock2),
    .err        (err2),
    .period_cnt (period_cnt2)
  );

  always #5 clk = ~clk;

  // Published periods are captured mid-cycle, one line per transaction.
  always @(negedge clk) begin
    if (meas_valid === 1'b1) begin
      cap_cnt  <= cap_cnt + 1;
      cap_h    <= high_len;
      cap_l    <= low_len;
      cap_p    <= period_len;
      cap_lock <= lock;
      cap_err  <= err;
      cap_pc   <= period_cnt;
      cap_t    <= $time;
      $display("[%0t] div15 pub h=%0d l=%0d p=%0d lock=%0b err=%0b cnt=%0d",
               $time, high_len, low_len, period_len, lock, err, period_cnt);
    end
    if (meas_valid2 === 1'b1) begin
      cap2_cnt <= cap2_cnt + 1;
      cap2_h   <= high_len2;
      cap2_l   <= low_len2;
      cap2_p   <= period_len2;
      $display("[%0t] div4 pub h=%0d l=%0d p=%0d lock=%0b err=%0b cnt=%0d",
               $time, high_len2, low_len2, period_len2, lock2, err2, period_cnt2);
    end
  end

  // One half-cycle of clk_div, changed just after a clk edge.
  task automatic hc(input logic v);
    @(clk);
    #1;
    if (v && !clk_div) begin
      rise_t   = $time;
      rise_pos = clk;
    end
    clk_div = v;
  endtask

  task automatic gen(input int h, input int l, input int n);
    repeat (n) begin
      repeat (h) hc(1'b1);
      repeat (l) hc(1'b0);
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    meas_en  = 1'b1;
    meas_en2 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({high_len, low_len, period_len, meas_valid, lock, err, period_cnt} !== 43'd0) begin
      n_fails++;
      $display("FAIL reset_outputs got %h required 0",
               {high_len, low_len, period_len, meas_valid, lock, err, period_cnt});
    end
    n_checks++;
    if ({high_len2, low_len2, period_len2, meas_valid2, lock2, err2, period_cnt2} !== 43'd0) begin
      n_fails++;
      $display("FAIL reset_outputs_div4 got %h required 0",
               {high_len2, low_len2, period_len2, meas_valid2, lock2, err2, period_cnt2});
    end
    rst_n = 1'b1;
    repeat (4) hc(1'b0);
    n_checks++;
    if ({meas_valid, lock, err, period_cnt} !== 19'd0) begin
      n_fails++;
      $display("FAIL idle_low_input got %h required 0", {meas_valid, lock, err, period_cnt});
    end
  endtask

  task automatic test_nominal_lock();
    int base;
    base = cap_cnt;
    gen(15, 15, 1);
    n_checks++;
    if (cap_cnt - base !== 0) begin
      n_fails++;
      $display("FAIL nom_first_edge_pubs got %0d required 0", cap_cnt - base);
    end
    gen(15, 15, 1);
    n_checks++;
    if (cap_cnt - base !== 1) begin
      n_fails++;
      $display("FAIL nom_second_edge_pubs got %0d required 1", cap_cnt - base);
    end
    n_checks++;
    if ({cap_h, cap_l, cap_p} !== {8'd15, 8'd15, 8'd30}) begin
      n_fails++;
      $display("FAIL nom_lengths got %0d/%0d/%0d required 15/15/30", cap_h, cap_l, cap_p);
    end
    n_checks++;
    if (int'(cap_t - rise_t) !== (rise_pos ? 14 : 9)) begin
      n_fails++;
      $display("FAIL nom_latency got %0d ns required %0d ns", int'(cap_t - rise_t),
               rise_pos ? 14 : 9);
    end
    gen(15, 15, 2);
    n_checks++;
    if ({cap_lock, cap_err} !== 2'b00) begin
      n_fails++;
      $display("FAIL nom_lock_at_3rd got lock=%0b err=%0b required 0/0", cap_lock, cap_err);
    end
    gen(15, 15, 1);
    n_checks++;
    if (cap_cnt - base !== 4 || {cap_lock, cap_err} !== 2'b10 || cap_pc !== 16'd4) begin
      n_fails++;
      $display("FAIL nom_lock_at_4th got pubs=%0d lock=%0b err=%0b cnt=%0d required 4/1/0/4",
               cap_cnt - base, cap_lock, cap_err, cap_pc);
    end
  endtask

  task automatic test_stretched_high();
    int base;
    base = cap_cnt;
    gen(16, 15, 1);
    gen(15, 15, 1);
    n_checks++;
    if (cap_cnt - base !== 2 || {cap_h, cap_l, cap_p} !== {8'd16, 8'd15, 8'd31}) begin
      n_fails++;
      $display("FAIL stretch_lengths got pubs=%0d %0d/%0d/%0d required 2 16/15/31",
               cap_cnt - base, cap_h, cap_l, cap_p);
    end
    n_checks++;
    if ({cap_lock, cap_err} !== 2'b01) begin
      n_fails++;
      $display("FAIL stretch_flags got lock=%0b err=%0b required 0/1", cap_lock, cap_err);
    end
    gen(15, 15, 4);
    n_checks++;
    if ({lock, err} !== 2'b11 || period_cnt !== 16'd10) begin
      n_fails++;
      $display("FAIL stretch_relock got lock=%0b err=%0b cnt=%0d required 1/1/10",
               lock, err, period_cnt);
    end
  endtask

  task automatic test_enable_drop();
    meas_en = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if ({lock, err, meas_valid, period_cnt} !== 19'd0) begin
      n_fails++;
      $display("FAIL endrop_clear got lock=%0b err=%0b valid=%0b cnt=%0d required 0",
               lock, err, meas_valid, period_cnt);
    end
    n_checks++;
    if ({high_len, low_len, period_len} !== {8'd15, 8'd15, 8'd30}) begin
      n_fails++;
      $display("FAIL endrop_hold got %0d/%0d/%0d required 15/15/30",
               high_len, low_len, period_len);
    end
    meas_en = 1'b1;
  endtask

  task automatic test_stuck_low();
    int base;
    base = cap_cnt;
    gen(15, 15, 1);
    repeat (200) hc(1'b0);
    n_checks++;
    if (err !== 1'b0) begin
      n_fails++;
      $display("FAIL stuck_early_err got %0b required 0", err);
    end
    repeat (400) hc(1'b0);
    n_checks++;
    if ({err, lock} !== 2'b10 || cap_cnt !== base || period_cnt !== 16'd0) begin
      n_fails++;
      $display("FAIL stuck_sat got err=%0b lock=%0b pubs=%0d cnt=%0d required 1/0/0/0",
               err, lock, cap_cnt - base, period_cnt);
    end
    gen(15, 15, 1);
    n_checks++;
    if (cap_cnt !== base) begin
      n_fails++;
      $display("FAIL stuck_resync_edge got pubs=%0d required 0", cap_cnt - base);
    end
    gen(15, 15, 1);
    n_checks++;
    if (cap_cnt - base !== 1 || {cap_h, cap_l, cap_p} !== {8'd15, 8'd15, 8'd30} ||
        cap_err !== 1'b1 || cap_pc !== 16'd1) begin
      n_fails++;
      $display("FAIL stuck_recover got pubs=%0d %0d/%0d/%0d err=%0b cnt=%0d required 1 15/15/30 1 1",
               cap_cnt - base, cap_h, cap_l, cap_p, cap_err, cap_pc);
    end
  endtask

  task automatic test_reset_mid();
    int base;
    gen(15, 15, 4);
    n_checks++;
    if (lock !== 1'b1) begin
      n_fails++;
      $display("FAIL rstmid_prelock got %0b required 1", lock);
    end
    fork
      gen(15, 15, 2);
      begin
        #100 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({high_len, low_len, period_len, meas_valid, lock, err, period_cnt} !== 43'd0) begin
          n_fails++;
          $display("FAIL rstmid_async got %h required 0",
                   {high_len, low_len, period_len, meas_valid, lock, err, period_cnt});
        end
      end
    join
    n_checks++;
    if ({high_len, low_len, period_len, meas_valid, lock, err, period_cnt} !== 43'd0) begin
      n_fails++;
      $display("FAIL rstmid_held got %h required 0",
               {high_len, low_len, period_len, meas_valid, lock, err, period_cnt});
    end
    #350 rst_n = 1'b1;
    base = cap_cnt;
    gen(15, 15, 1);
    n_checks++;
    if (cap_cnt !== base) begin
      n_fails++;
      $display("FAIL rstmid_first_edge got pubs=%0d required 0", cap_cnt - base);
    end
    gen(15, 15, 1);
    n_checks++;
    if (cap_cnt - base !== 1 || {cap_h, cap_l, cap_p} !== {8'd15, 8'd15, 8'd30} ||
        cap_pc !== 16'd1 || cap_err !== 1'b0) begin
      n_fails++;
      $display("FAIL rstmid_first_pub got pubs=%0d %0d/%0d/%0d cnt=%0d err=%0b required 1 15/15/30 1 0",
               cap_cnt - base, cap_h, cap_l, cap_p, cap_pc, cap_err);
    end
  endtask

  task automatic test_even_ratio();
    int base;
    base = cap2_cnt;
    for (int p = 1; p <= 5; p++) begin
      @(posedge clk);
      #1 clk_div2 = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1 clk_div2 = 1'b0;
      @(posedge clk);
      #1;
      if (p == 4) begin
        n_checks++;
        if (cap2_cnt - base !== 3 || lock2 !== 1'b0) begin
          n_fails++;
          $display("FAIL even_prelock got pubs=%0d lock=%0b required 3/0", cap2_cnt - base, lock2);
        end
      end
    end
    n_checks++;
    if (cap2_cnt - base !== 4 || {cap2_h, cap2_l, cap2_p} !== {8'd4, 8'd4, 8'd8}) begin
      n_fails++;
      $display("FAIL even_lengths got pubs=%0d %0d/%0d/%0d required 4 4/4/8",
               cap2_cnt - base, cap2_h, cap2_l, cap2_p);
    end
    n_checks++;
    if ({lock2, err2} !== 2'b10 || period_cnt2 !== 16'd4) begin
      n_fails++;
      $display("FAIL even_lock got lock=%0b err=%0b cnt=%0d required 1/0/4", lock2, err2, period_cnt2);
    end
  endtask

  initial begin
    test_reset();
    test_nominal_lock();
    test_stretched_high();
    test_enable_drop();
    test_stuck_low();
    test_reset_mid();
    test_even_ratio();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
